ex_mem_pipe: RTL and testbench
==============================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of wdata/hi/lo.
REQ-002 Parameter ADDR_W, default 5, register-address width.
REQ-003 Parameter SKID, default 1; 1 = two-entry skid buffer with registered ex_ready, 0 = single register with ex_ready = !mem_valid | mem_ready.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ex_valid  in  1  EX presents an instruction result.
REQ-007 ex_ready  out  1  stage can accept this cycle.
REQ-008 ex_wd  in  ADDR_W;  ex_wreg  in  1;  ex_wdata  in  DATA_W  GPR write-back fields.
REQ-009 ex_hi, ex_lo  in  DATA_W;  ex_whilo  in  1  HI/LO write-back fields.
REQ-010 ex_acc_we  in  1;  ex_hilo_tmp  in  2*DATA_W;  ex_cnt  in  2  multi-cycle madd/msub partial state from EX.
REQ-011 flush  in  1  kill all held instructions.
REQ-012 mem_ready  in  1  MEM accepts head entry.
REQ-013 mem_valid  out  1  head entry valid.
REQ-014 mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo  out  same widths as EX fields.
REQ-015 hilo_tmp_o  out  2*DATA_W;  cnt_o  out  2  partial state returned to EX.

Function
REQ-016 Accept = ex_valid & ex_ready; release = mem_valid & mem_ready.
REQ-017 Entry = {wd, wreg, wdata, hi, lo, whilo}; head register drives mem_* outputs.
REQ-018 SKID=1 states: EMPTY (no entries), ONE (head full), TWO (head + skid full).
REQ-019 EMPTY: accept -> ONE, entry into head.
REQ-020 ONE: accept & !release -> TWO, entry into skid; accept & release -> ONE, entry into head; release only -> EMPTY.
REQ-021 TWO: release -> ONE, skid moves to head; no accept possible.
REQ-022 ex_ready (SKID=1) is a flop equal to 1 in EMPTY/ONE, 0 in TWO; never combinationally depends on mem_ready.
REQ-023 Latency EX->MEM: 1 cycle when empty; head data stable while mem_valid & !mem_ready.
REQ-024 mem_wreg and mem_whilo are 0 whenever mem_valid is 0 (bubbles never write).
REQ-025 flush: next state EMPTY, mem_valid=0, ex_ready=1; flush overrides simultaneous accept and release.
REQ-026 Accumulator {hilo_tmp_o, cnt_o}: loaded from {ex_hilo_tmp, ex_cnt} on any cycle ex_acc_we=1, independent of handshake.
REQ-027 Accumulator cleared to zero on accept with ex_acc_we=0, and on flush; flush wins over ex_acc_we.
REQ-028 SKID=0: single state bit; head loads on accept; identical output semantics otherwise.
REQ-029 Data fields in non-valid slots are don't-care except as required by REQ-024.

Reset
REQ-030 On rst assertion, immediately: state EMPTY, mem_valid=0, mem_wd=NOP register address (0), mem_wreg=0, mem_wdata/mem_hi/mem_lo=0, mem_whilo=0, hilo_tmp_o=0, cnt_o=0.
REQ-031 ex_ready = 0 while rst asserted; 1 on first clock edge after deassertion.
REQ-032 Reset mid-transfer discards both entries; no partial entry is observable after release.

Structure
REQ-033 Shared define file carries RstEnable, WriteDisable, ZeroWord, NOPRegAddr and the 2-bit state encodings EMPTY=00, ONE=01, TWO=10.
REQ-034 One sub-module, ex_mem_slot: parametrised entry register with load enable and valid bit, instantiated as head and skid.

Verification
REQ-035 Reset release, ex_valid=1, wd=5, wdata=0x12345678, mem_ready=1 -> next cycle mem_valid=1, mem_wd=5, mem_wdata=0x12345678.
REQ-036 mem_ready=0 with three back-to-back ex_valid (wdata 1,2,3) -> first two accepted, ex_ready=0 after second, third held; mem_ready=1 -> MEM sees 1,2,3 in order, none lost or duplicated.
REQ-037 TWO state with ex_valid=1, mem_ready=1 and flush=1 same cycle -> next cycle mem_valid=0, mem_wreg=0, ex_ready=1.
REQ-038 ex_acc_we=1, hilo_tmp=0x0000_0001_FFFF_FFFF, cnt=1 for two cycles, then accept with ex_acc_we=0 -> hilo_tmp_o holds value, then returns to 0 with cnt_o=0.
REQ-039 rst asserted asynchronously between edges while in ONE -> outputs zero before next edge; mem_wd=0.
REQ-040 SKID=0 build, mem_ready toggling every cycle with continuous ex_valid -> ex_ready tracks !mem_valid | mem_ready each cycle, sequence preserved.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and state encodings for the EX/MEM pipeline register.
package ex_mem_pipe_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_e;

endpackage

// File: rtl/ex_mem_slot.sv
// One EX/MEM entry register with a load enable and its own valid bit.
module ex_mem_slot
    import ex_mem_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Reset clears the data too, so a fresh pipe shows a NOP on every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: optional two-entry skid buffer plus the
// madd/msub accumulator state that is handed back to EX.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SKID   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic                ex_acc_we,
    input  logic [2*DATA_W-1:0] ex_hilo_tmp,
    input  logic [1:0]          ex_cnt,
    input  logic                flush,
    input  logic                mem_ready,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_tmp_o,
    output logic [1:0]          cnt_o
);

    localparam int EW = ADDR_W + 3 * DATA_W + 2;

    logic [EW-1:0] ex_entry;
    logic [EW-1:0] head_d;
    logic [EW-1:0] head_q;
    logic          head_ld;
    logic          head_vin;
    logic          head_valid;
    logic          accept;
    logic          rel;
    logic          head_wreg;
    logic          head_whilo;

    assign ex_entry = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo};
    assign accept   = ex_valid & ex_ready;
    assign rel      = head_valid & mem_ready;

    ex_mem_slot #(.W(EW)) u_head (
        .clk     (clk),
        .rst     (rst),
        .load_i  (head_ld),
        .valid_i (head_vin),
        .data_i  (head_d),
        .valid_o (head_valid),
        .data_o  (head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            state_e        state_q;
            state_e        state_d;
            logic          ready_q;
            logic          ready_d;
            logic          skid_ld;
            logic          skid_vin;
            logic          skid_valid;
            logic [EW-1:0] skid_q;
            logic          sel_skid;

            ex_mem_slot #(.W(EW)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load_i  (skid_ld),
                .valid_i (skid_vin),
                .data_i  (ex_entry),
                .valid_o (skid_valid),
                .data_o  (skid_q)
            );

            // ex_ready is registered so it never depends on mem_ready in the same cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst == RstEnable) begin
                    state_q <= EMPTY;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= ready_d;
                end
            end

            always_comb begin
                state_d  = state_q;
                head_ld  = 1'b0;
                head_vin = 1'b0;
                skid_ld  = 1'b0;
                skid_vin = 1'b0;
                sel_skid = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                    head_ld = 1'b1;
                    skid_ld = 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                state_d  = ONE;
                                head_ld  = 1'b1;
                                head_vin = 1'b1;
                            end
                        end
                        ONE: begin
                            if (accept && !rel) begin
                                state_d  = TWO;
                                skid_ld  = 1'b1;
                                skid_vin = 1'b1;
                            end else if (accept) begin
                                head_ld  = 1'b1;
                                head_vin = 1'b1;
                            end else if (rel) begin
                                state_d = EMPTY;
                                head_ld = 1'b1;
                            end
                        end
                        TWO: begin
                            if (rel) begin
                                state_d  = ONE;
                                head_ld  = 1'b1;
                                head_vin = skid_valid;
                                sel_skid = 1'b1;
                                skid_ld  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = EMPTY;
                            head_ld = 1'b1;
                            skid_ld = 1'b1;
                        end
                    endcase
                end
                ready_d = (state_d != TWO);
            end

            assign head_d   = sel_skid ? skid_q : ex_entry;
            assign ex_ready = ready_q;
        end else begin : g_single
            // The head valid bit is the whole state here.
            always_comb begin
                head_ld  = 1'b0;
                head_vin = 1'b0;
                if (flush) begin
                    head_ld = 1'b1;
                end else if (accept) begin
                    head_ld  = 1'b1;
                    head_vin = 1'b1;
                end else if (rel) begin
                    head_ld = 1'b1;
                end
            end

            assign head_d   = ex_entry;
            assign ex_ready = !rst & (!head_valid | mem_ready);
        end
    endgenerate

    assign {mem_wd, head_wreg, mem_wdata, mem_hi, mem_lo, head_whilo} = head_q;
    assign mem_valid = head_valid;
    assign mem_wreg  = head_valid ? head_wreg  : WriteDisable;
    assign mem_whilo = head_valid ? head_whilo : WriteDisable;

    logic [2*DATA_W+1:0] acc_q;
    logic [2*DATA_W+1:0] acc_d;

    // Partial madd/msub state follows EX writes regardless of the handshake.
    always_comb begin
        acc_d = acc_q;
        if (flush) begin
            acc_d = '0;
        end else if (ex_acc_we) begin
            acc_d = {ex_hilo_tmp, ex_cnt};
        end else if (accept) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign {hilo_tmp_o, cnt_o} = acc_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Drives a SKID=1 and a SKID=0 instance with the same stimulus and checks both
// against queue-based models of the EX/MEM stage.
module tb_ex_mem_pipe;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic          whilo;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic [AW-1:0] ex_wd = '0;
    logic          ex_wreg = 1'b0;
    logic [DW-1:0] ex_wdata = '0;
    logic [DW-1:0] ex_hi = '0;
    logic [DW-1:0] ex_lo = '0;
    logic          ex_whilo = 1'b0;
    logic          ex_acc_we = 1'b0;
    logic [2*DW-1:0] ex_hilo_tmp = '0;
    logic [1:0]    ex_cnt = '0;
    logic          flush = 1'b0;
    logic          mem_ready = 1'b0;

    logic          s1_ex_ready, s1_mem_valid, s1_mem_wreg, s1_mem_whilo;
    logic [AW-1:0] s1_mem_wd;
    logic [DW-1:0] s1_mem_wdata, s1_mem_hi, s1_mem_lo;
    logic [2*DW-1:0] s1_hilo;
    logic [1:0]    s1_cnt;

    logic          s0_ex_ready, s0_mem_valid, s0_mem_wreg, s0_mem_whilo;
    logic [AW-1:0] s0_mem_wd;
    logic [DW-1:0] s0_mem_wdata, s0_mem_hi, s0_mem_lo;
    logic [2*DW-1:0] s0_hilo;
    logic [1:0]    s0_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .SKID(1)) u_skid1 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(s1_ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi),
        .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_acc_we(ex_acc_we),
        .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt), .flush(flush),
        .mem_ready(mem_ready), .mem_valid(s1_mem_valid), .mem_wd(s1_mem_wd),
        .mem_wreg(s1_mem_wreg), .mem_wdata(s1_mem_wdata), .mem_hi(s1_mem_hi),
        .mem_lo(s1_mem_lo), .mem_whilo(s1_mem_whilo), .hilo_tmp_o(s1_hilo),
        .cnt_o(s1_cnt)
    );

    ex_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .SKID(0)) u_skid0 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(s0_ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi),
        .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_acc_we(ex_acc_we),
        .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt), .flush(flush),
        .mem_ready(mem_ready), .mem_valid(s0_mem_valid), .mem_wd(s0_mem_wd),
        .mem_wreg(s0_mem_wreg), .mem_wdata(s0_mem_wdata), .mem_hi(s0_mem_hi),
        .mem_lo(s0_mem_lo), .mem_whilo(s0_mem_whilo), .hilo_tmp_o(s0_hilo),
        .cnt_o(s0_cnt)
    );

    entry_t s1Ent, s0Ent;
    assign s1Ent = {s1_mem_wd, s1_mem_wreg, s1_mem_wdata, s1_mem_hi, s1_mem_lo, s1_mem_whilo};
    assign s0Ent = {s0_mem_wd, s0_mem_wreg, s0_mem_wdata, s0_mem_hi, s0_mem_lo, s0_mem_whilo};

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: FIFO of capacity 2 (skid) or 1 (single), plus accumulator rules.
    entry_t        q1[$];
    entry_t        q0[$];
    bit            rdy1 = 1'b0;
    logic [2*DW+1:0] acc1 = '0;
    logic [2*DW+1:0] acc0 = '0;
    bit            a1, r1, a0, r0, rdy0;
    entry_t        eIn;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            q0.delete();
            rdy1 = 1'b0;
            acc1 = '0;
            acc0 = '0;
        end else begin
            eIn  = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo};
            rdy0 = (q0.size() == 0) || mem_ready;
            a1 = ex_valid && rdy1;
            r1 = (q1.size() > 0) && mem_ready;
            a0 = ex_valid && rdy0;
            r0 = (q0.size() > 0) && mem_ready;
            if (flush) q1.delete();
            else begin
                if (r1) void'(q1.pop_front());
                if (a1) q1.push_back(eIn);
            end
            if (flush) q0.delete();
            else begin
                if (r0) void'(q0.pop_front());
                if (a0) q0.push_back(eIn);
            end
            rdy1 = q1.size() < 2;
            acc1 = flush ? '0 : ex_acc_we ? {ex_hilo_tmp, ex_cnt} : a1 ? '0 : acc1;
            acc0 = flush ? '0 : ex_acc_we ? {ex_hilo_tmp, ex_cnt} : a0 ? '0 : acc0;
        end
    end

    task automatic compareDut(input string tag, input bit expValid, input entry_t expHead,
                              input bit expRdy, input logic [2*DW+1:0] expAcc,
                              input bit actValid, input entry_t actEnt, input bit actRdy,
                              input logic [2*DW+1:0] actAcc);
        checkOutput({tag, ".mem_valid"}, actValid, expValid);
        checkOutput({tag, ".ex_ready"}, actRdy, expRdy);
        checkOutput({tag, ".acc"}, actAcc, expAcc);
        if (expValid) begin
            checkOutput({tag, ".entry"}, actEnt, expHead);
        end else begin
            checkOutput({tag, ".bubble_wreg"}, actEnt.wreg, 1'b0);
            checkOutput({tag, ".bubble_whilo"}, actEnt.whilo, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            compareDut("s1", q1.size() > 0, (q1.size() > 0) ? q1[0] : entry_t'('0), rdy1, acc1,
                       s1_mem_valid, s1Ent, s1_ex_ready, {s1_hilo, s1_cnt});
            compareDut("s0", q0.size() > 0, (q0.size() > 0) ? q0[0] : entry_t'('0),
                       (q0.size() == 0) || mem_ready, acc0,
                       s0_mem_valid, s0Ent, s0_ex_ready, {s0_hilo, s0_cnt});
        end
    end

    task automatic applyStimulus(input bit v, input logic [AW-1:0] wd, input bit wreg,
                                 input logic [DW-1:0] wdata, input bit mr, input bit fl);
        ex_valid  = v;
        ex_wd     = wd;
        ex_wreg   = wreg;
        ex_wdata  = wdata;
        mem_ready = mr;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        checkOutput("rst.mem_valid", s1_mem_valid, 1'b0);
        checkOutput("rst.mem_wd", s1_mem_wd, 5'd0);
        checkOutput("rst.mem_wdata", s1_mem_wdata, 32'd0);
        checkOutput("rst.mem_wreg", s1_mem_wreg, 1'b0);
        checkOutput("rst.ex_ready", s1_ex_ready, 1'b0);
        checkOutput("rst.hilo", s1_hilo, 64'd0);
        checkOutput("rst.cnt", s1_cnt, 2'd0);
        checkOutput("rst.s0_ex_ready", s0_ex_ready, 1'b0);
        rst = 1'b0;
        checkOutput("rel.ex_ready_low", s1_ex_ready, 1'b0);
        tick();
        checkOutput("rel.ex_ready_high", s1_ex_ready, 1'b1);

        applyStimulus(1'b1, 5'd5, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("lat.mem_valid", s1_mem_valid, 1'b1);
        checkOutput("lat.mem_wd", s1_mem_wd, 5'd5);
        checkOutput("lat.mem_wdata", s1_mem_wdata, 32'h1234_5678);
        checkOutput("lat.s0_mem_wdata", s0_mem_wdata, 32'h1234_5678);
        tick();

        applyStimulus(1'b1, 5'd1, 1'b1, 32'd1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd1, 1'b1, 32'd2, 1'b0, 1'b0);
        tick();
        checkOutput("bp.ready_full", s1_ex_ready, 1'b0);
        applyStimulus(1'b1, 5'd1, 1'b1, 32'd3, 1'b0, 1'b0);
        tick();
        checkOutput("bp.head_stable", s1_mem_wdata, 32'd1);
        applyStimulus(1'b1, 5'd1, 1'b1, 32'd3, 1'b1, 1'b0);
        tick();
        checkOutput("bp.second", s1_mem_wdata, 32'd2);
        checkOutput("bp.ready_back", s1_ex_ready, 1'b1);
        tick();
        checkOutput("bp.third", s1_mem_wdata, 32'd3);
        checkOutput("bp.third_valid", s1_mem_valid, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("bp.drained", s1_mem_valid, 1'b0);

        applyStimulus(1'b1, 5'd2, 1'b1, 32'hA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd3, 1'b1, 32'hB, 1'b0, 1'b0);
        tick();
        checkOutput("fl.two_ready", s1_ex_ready, 1'b0);
        applyStimulus(1'b1, 5'd4, 1'b1, 32'hC, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("fl.mem_valid", s1_mem_valid, 1'b0);
        checkOutput("fl.mem_wreg", s1_mem_wreg, 1'b0);
        checkOutput("fl.ex_ready", s1_ex_ready, 1'b1);

        ex_acc_we   = 1'b1;
        ex_hilo_tmp = 64'h0000_0001_FFFF_FFFF;
        ex_cnt      = 2'd1;
        tick();
        checkOutput("acc.load1", s1_hilo, 64'h0000_0001_FFFF_FFFF);
        checkOutput("acc.cnt1", s1_cnt, 2'd1);
        tick();
        checkOutput("acc.load2", s1_hilo, 64'h0000_0001_FFFF_FFFF);
        ex_acc_we = 1'b0;
        applyStimulus(1'b1, 5'd6, 1'b1, 32'h66, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("acc.clear", s1_hilo, 64'd0);
        checkOutput("acc.cnt_clear", s1_cnt, 2'd0);
        tick();

        applyStimulus(1'b1, 5'd7, 1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("ar.one_valid", s1_mem_valid, 1'b1);
        checkOutput("ar.one_wd", s1_mem_wd, 5'd7);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("ar.mem_valid", s1_mem_valid, 1'b0);
        checkOutput("ar.mem_wd", s1_mem_wd, 5'd0);
        checkOutput("ar.mem_wdata", s1_mem_wdata, 32'd0);
        checkOutput("ar.ex_ready", s1_ex_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 5'($urandom), 1'($urandom), $urandom, 1'(i % 2), 1'b0);
            tick();
        end

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 4) != 0, 5'($urandom), 1'($urandom), $urandom,
                          (i < 1500) ? (($urandom % 3) == 0) : (($urandom % 3) != 0),
                          ($urandom % 32) == 0);
            ex_hi       = $urandom;
            ex_lo       = $urandom;
            ex_whilo    = 1'($urandom);
            ex_acc_we   = ($urandom % 4) == 0;
            ex_hilo_tmp = {$urandom, $urandom};
            ex_cnt      = 2'($urandom);
            tick();
        end

        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        ex_acc_we = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
